// File: rtl/button_event_classifier.sv
// Classifies a debounced button level into short-press, long-press and double-click strobes.
// A single dwell counter times both the long-press threshold and the double-click window.
module button_event_classifier #(
  parameter logic [15:0] LONG_CNT   = 16'd50000,
  parameter logic [15:0] DCLICK_CNT = 16'd25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       double_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  typedef enum logic [2:0] {
    S_WAIT_RELEASE  = 3'd0,
    S_IDLE          = 3'd1,
    S_PRESSED       = 3'd2,
    S_LONG_HELD     = 3'd3,
    S_WAIT_SECOND   = 3'd4,
    S_SECOND_PRESSED = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_press_count;
  logic        r_short;
  logic        r_long;
  logic        r_double;
  logic        r_held;

  logic        w_long_hit;
  logic        w_dclick_hit;

  assign w_long_hit   = (r_cnt == LONG_CNT - 16'd1);
  assign w_dclick_hit = (r_cnt == DCLICK_CNT - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_WAIT_RELEASE;
      r_cnt         <= 16'd0;
      r_press_count <= 8'd0;
      r_short       <= 1'b0;
      r_long        <= 1'b0;
      r_double      <= 1'b0;
      r_held        <= 1'b0;
    end else begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      // Every armed state with btn high lands in a held state next cycle.
      r_held   <= btn && (r_state != S_WAIT_RELEASE);
      case (r_state)
        S_WAIT_RELEASE: begin
          if (!btn) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (btn) begin
            r_state       <= S_PRESSED;
            r_cnt         <= 16'd1;
            r_press_count <= r_press_count + 8'd1;
          end
        end
        S_PRESSED: begin
          if (btn) begin
            if (w_long_hit) begin
              r_state <= S_LONG_HELD;
              r_long  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end else begin
            r_state <= S_WAIT_SECOND;
            r_cnt   <= 16'd1;
          end
        end
        S_LONG_HELD: begin
          if (!btn) r_state <= S_IDLE;
        end
        S_WAIT_SECOND: begin
          // A press arriving on the expiry cycle wins over the short strobe.
          if (btn) begin
            r_state       <= S_SECOND_PRESSED;
            r_press_count <= r_press_count + 8'd1;
          end else if (w_dclick_hit) begin
            r_state <= S_IDLE;
            r_short <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_SECOND_PRESSED: begin
          if (!btn) begin
            r_state  <= S_IDLE;
            r_double <= 1'b1;
          end
        end
        default: r_state <= S_WAIT_RELEASE;
      endcase
    end
  end

  assign short_pulse  = r_short;
  assign long_pulse   = r_long;
  assign double_pulse = r_double;
  assign held         = r_held;
  assign press_count  = r_press_count;

endmodule

// File: doc/button_event_classifier.md
BUTTON_EVENT_CLASSIFIER -- requirements
Module: button_event_classifier

Interface
REQ-001 SHALL have parameter LONG_CNT, default 16'd50000: consecutive high samples of btn that qualify a long press; legal range 2..65535.
REQ-002 SHALL have parameter DCLICK_CNT, default 16'd25000: consecutive low samples after a first release that close the double-click window; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port btn, input, 1 bit: debounced button level from the debounce stage, active-high, already synchronous to clk.
REQ-006 SHALL have port short_pulse, output, 1 bit: one-cycle strobe for a single short press.
REQ-007 SHALL have port long_pulse, output, 1 bit: one-cycle strobe for a long press.
REQ-008 SHALL have port double_pulse, output, 1 bit: one-cycle strobe for a double click.
REQ-009 SHALL have port held, output, 1 bit: high while the FSM is in PRESSED, LONG_HELD or SECOND_PRESSED.
REQ-010 SHALL have port press_count, output, 8 bits: count of recognised press onsets.

Function
REQ-011 SHALL implement FSM states WAIT_RELEASE, IDLE, PRESSED, LONG_HELD, WAIT_SECOND and SECOND_PRESSED, with one 16-bit dwell counter cnt.
REQ-012 WAIT_RELEASE: btn=0 -> IDLE; btn=1 -> stay; no press recognised.
REQ-013 IDLE: btn=1 -> PRESSED, cnt<=1, press_count increments.
REQ-014 PRESSED, btn=1, cnt==LONG_CNT-1 -> LONG_HELD, long_pulse=1 next cycle.
REQ-015 PRESSED, btn=1 otherwise -> cnt increments.
REQ-016 PRESSED, btn=0 -> WAIT_SECOND, cnt<=1.
REQ-017 LONG_HELD: btn=0 -> IDLE; no further pulse, however long btn is held.
REQ-018 WAIT_SECOND, btn=0, cnt==DCLICK_CNT-1 -> IDLE, short_pulse=1 next cycle.
REQ-019 WAIT_SECOND, btn=0 otherwise -> cnt increments.
REQ-020 WAIT_SECOND, btn=1 -> SECOND_PRESSED, press_count increments.
REQ-021 SECOND_PRESSED: btn=0 -> IDLE, double_pulse=1 next cycle, regardless of second-press duration; no long_pulse from this state.
REQ-022 When btn=1 arrives in WAIT_SECOND on the same cycle cnt would expire, the press SHALL win: go to SECOND_PRESSED and emit no short_pulse.
REQ-023 All outputs SHALL be registered; at most one of short_pulse/long_pulse/double_pulse is high in any cycle, each high for exactly one cycle per event.
REQ-024 press_count SHALL wrap 8'hFF -> 8'h00 with no saturation or flag.
REQ-025 cnt SHALL never exceed max(LONG_CNT, DCLICK_CNT)-1; no 16-bit overflow path exists.
REQ-026 held SHALL be registered and asserted from the cycle after the IDLE->PRESSED transition.

Reset
REQ-027 rst_n=0 sampled at a clk edge SHALL force state WAIT_RELEASE, cnt=0, press_count=0, and short_pulse, long_pulse, double_pulse and held all 0 from the following cycle.
REQ-028 Reset mid-operation, in any state, SHALL abandon the gesture with no pulse emitted; a btn held high through reset SHALL not count as a press until it has been seen low.
REQ-029 Reset SHALL take priority over every FSM transition in the same cycle.

Verification (LONG_CNT=8, DCLICK_CNT=4)
REQ-030 btn high 3 cycles, then low 4 cycles -> exactly one short_pulse, press_count=1, no other pulses.
REQ-031 btn high 20 cycles -> long_pulse once, on the cycle after the 8th high sample; held=1 throughout; release -> no pulse.
REQ-032 btn high 2, low 2, high 2, low -> double_pulse once, the cycle after the first low sample of the second release; press_count=2; no short_pulse.
REQ-033 btn high 2, low 3, high on what would be the 4th low cycle -> no short_pulse; double_pulse after the next release.
REQ-034 rst_n low for 1 cycle during PRESSED with btn held high -> all outputs 0, no long_pulse; btn low then high -> press_count=1.
REQ-035 256 short presses -> press_count returns to 8'h00; 256 short_pulse strobes counted.
